// File: rtl/life_cell_gen.sv
// One cell of a Generations-style cellular automaton with programmable B/S rule masks and an output shift chain.
// Optional macro AGE_CNT_EN adds a saturating counter of generations continuously alive.
module life_cell_gen #(
    parameter int unsigned STATES = 2,
    parameter int unsigned SW     = (STATES > 2) ? $clog2(STATES) : 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [7:0]       nbr,
    input  logic             load_in,
    input  logic [SW-1:0]    in_data,
    input  logic             rule_we,
    input  logic [8:0]       rule_birth,
    input  logic [8:0]       rule_survive,
    input  logic             load_out,
    input  logic             shift,
    input  logic [SW-1:0]    prev_out_data,
    output logic [SW-1:0]    out_data,
    output logic [SW-1:0]    state,
    output logic             alive,
    output logic [CNT_W-1:0] age
);

    localparam logic [SW-1:0] ST_DEAD   = '0;
    localparam logic [SW-1:0] ST_ALIVE  = SW'(1);
    localparam logic [SW-1:0] ST_LAST   = SW'(STATES - 1);
    localparam logic [SW-1:0] ST_DYING0 = (STATES > 2) ? SW'(2) : '0;

    logic [3:0]    count;
    logic [SW-1:0] state_d;
    logic [SW-1:0] out_d;
    logic [8:0]    birth_q;
    logic [8:0]    survive_q;

    // Number of live neighbours, 0..8
    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + 4'(nbr[i]);
        end
    end

    // Next cell state and next output-chain stage; run beats load_in, load_out beats shift
    always_comb begin
        state_d = state;
        out_d   = out_data;
        if (run) begin
            if (state == ST_DEAD) begin
                state_d = birth_q[count] ? ST_ALIVE : ST_DEAD;
            end else if (state == ST_ALIVE) begin
                state_d = survive_q[count] ? ST_ALIVE : ST_DYING0;
            end else begin
                state_d = (state == ST_LAST) ? ST_DEAD : state + SW'(1);
            end
        end else if (load_in) begin
            state_d = (32'(in_data) >= STATES) ? ST_DEAD : in_data;
        end
        if (load_out) begin
            out_d = state;
        end else if (shift) begin
            out_d = prev_out_data;
        end
    end

    // Registers; alive is kept as its own flop so neighbours see a clean register output
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_DEAD;
            alive     <= 1'b0;
            out_data  <= '0;
            birth_q   <= 9'h008;
            survive_q <= 9'h00C;
        end else begin
            state    <= state_d;
            alive    <= (state_d == ST_ALIVE);
            out_data <= out_d;
            if (rule_we) begin
                birth_q   <= rule_birth;
                survive_q <= rule_survive;
            end
        end
    end

`ifdef AGE_CNT_EN
    logic [CNT_W-1:0] age_q;
    logic [CNT_W-1:0] age_d;

    // Count only alive-to-alive generations, saturating; anything else restarts at zero
    always_comb begin
        age_d = age_q;
        if (run) begin
            if ((state == ST_ALIVE) && (state_d == ST_ALIVE)) begin
                age_d = (&age_q) ? age_q : age_q + CNT_W'(1);
            end else begin
                age_d = '0;
            end
        end else if (load_in) begin
            age_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    assign age = age_q;
`else
    assign age = '0;
`endif

endmodule

// File: tb/tb_life_cell_gen.sv
// Bench for life_cell_gen: directed rule scenarios plus randomized traffic against an integer reference model.
// Instances: STATES=2, STATES=5, and a 3-cell STATES=4 shift chain.
module tb_life_cell_gen;

`ifdef AGE_CNT_EN
    localparam bit AGE_EN = 1'b1;
`else
    localparam bit AGE_EN = 1'b0;
`endif
    localparam int AGE_MAX = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, run, load_in, rule_we, load_out, shift;
    logic [7:0] nbr;
    logic [8:0] rule_birth, rule_survive;
    logic [2:0] din_x, prev_x;
    logic [1:0] dc [3];

    logic       st_a, od_a, al_a;
    logic [1:0] ag_a;
    logic [2:0] st_b, od_b;
    logic       al_b;
    logic [1:0] ag_b;
    logic [1:0] st_c [3];
    logic [1:0] od_c [3];
    logic       al_c [3];
    logic [1:0] ag_c [3];

    life_cell_gen #(.STATES(2), .CNT_W(2)) u_a (
        .clk(clk), .reset(reset), .run(run), .nbr(nbr), .load_in(load_in), .in_data(din_x[0:0]),
        .rule_we(rule_we), .rule_birth(rule_birth), .rule_survive(rule_survive),
        .load_out(load_out), .shift(shift), .prev_out_data(prev_x[0:0]),
        .out_data(od_a), .state(st_a), .alive(al_a), .age(ag_a));

    life_cell_gen #(.STATES(5), .CNT_W(2)) u_b (
        .clk(clk), .reset(reset), .run(run), .nbr(nbr), .load_in(load_in), .in_data(din_x),
        .rule_we(rule_we), .rule_birth(rule_birth), .rule_survive(rule_survive),
        .load_out(load_out), .shift(shift), .prev_out_data(prev_x),
        .out_data(od_b), .state(st_b), .alive(al_b), .age(ag_b));

    life_cell_gen #(.STATES(4), .CNT_W(2)) u_c0 (
        .clk(clk), .reset(reset), .run(run), .nbr(nbr), .load_in(load_in), .in_data(dc[0]),
        .rule_we(rule_we), .rule_birth(rule_birth), .rule_survive(rule_survive),
        .load_out(load_out), .shift(shift), .prev_out_data(prev_x[1:0]),
        .out_data(od_c[0]), .state(st_c[0]), .alive(al_c[0]), .age(ag_c[0]));

    life_cell_gen #(.STATES(4), .CNT_W(2)) u_c1 (
        .clk(clk), .reset(reset), .run(run), .nbr(nbr), .load_in(load_in), .in_data(dc[1]),
        .rule_we(rule_we), .rule_birth(rule_birth), .rule_survive(rule_survive),
        .load_out(load_out), .shift(shift), .prev_out_data(od_c[0]),
        .out_data(od_c[1]), .state(st_c[1]), .alive(al_c[1]), .age(ag_c[1]));

    life_cell_gen #(.STATES(4), .CNT_W(2)) u_c2 (
        .clk(clk), .reset(reset), .run(run), .nbr(nbr), .load_in(load_in), .in_data(dc[2]),
        .rule_we(rule_we), .rule_birth(rule_birth), .rule_survive(rule_survive),
        .load_out(load_out), .shift(shift), .prev_out_data(od_c[1]),
        .out_data(od_c[2]), .state(st_c[2]), .alive(al_c[2]), .age(ag_c[2]));

    typedef struct {
        int         st;
        int         od;
        int         age;
        logic [8:0] b;
        logic [8:0] s;
    } cell_m_t;

    cell_m_t m [5];
    int n_chk  = 0;
    int n_pass = 0;

    // Reference: one generation of a cell written directly from the rules, using current bench inputs
    function automatic cell_m_t step(cell_m_t c, int states, int din, int prev);
        cell_m_t n = c;
        int cnt = $countones(nbr);
        int ns;
        if (reset) begin
            n.st = 0; n.od = 0; n.age = 0; n.b = 9'h008; n.s = 9'h00C;
            return n;
        end
        if (rule_we) begin
            n.b = rule_birth;
            n.s = rule_survive;
        end
        if (run) begin
            if (c.st == 0)      ns = c.b[cnt] ? 1 : 0;
            else if (c.st == 1) ns = c.s[cnt] ? 1 : ((states > 2) ? 2 : 0);
            else                ns = (c.st == states - 1) ? 0 : c.st + 1;
            n.age = (AGE_EN && c.st == 1 && ns == 1) ? ((c.age < AGE_MAX) ? c.age + 1 : AGE_MAX) : 0;
            n.st  = ns;
        end else if (load_in) begin
            n.st  = (din >= states) ? 0 : din;
            n.age = 0;
        end
        if (load_out)   n.od = c.st;
        else if (shift) n.od = prev;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_cell(input string nm, input logic [31:0] st, input logic [31:0] od,
                            input logic al, input logic [31:0] ag, input cell_m_t c);
        chk({nm, ".state"}, st, c.st);
        chk({nm, ".out_data"}, od, c.od);
        chk({nm, ".alive"}, 32'(al), 32'(c.st == 1));
        chk({nm, ".age"}, ag, c.age);
    endtask

    task automatic cyc();
        cell_m_t nx [5];
        nx[0] = step(m[0], 2, int'(din_x[0]), int'(prev_x[0]));
        nx[1] = step(m[1], 5, int'(din_x), int'(prev_x));
        nx[2] = step(m[2], 4, int'(dc[0]), int'(prev_x[1:0]));
        nx[3] = step(m[3], 4, int'(dc[1]), m[2].od);
        nx[4] = step(m[4], 4, int'(dc[2]), m[3].od);
        @(posedge clk);
        #1;
        m = nx;
        chk_cell("a", 32'(st_a), 32'(od_a), al_a, 32'(ag_a), m[0]);
        chk_cell("b", 32'(st_b), 32'(od_b), al_b, 32'(ag_b), m[1]);
        chk_cell("c0", 32'(st_c[0]), 32'(od_c[0]), al_c[0], 32'(ag_c[0]), m[2]);
        chk_cell("c1", 32'(st_c[1]), 32'(od_c[1]), al_c[1], 32'(ag_c[1]), m[3]);
        chk_cell("c2", 32'(st_c[2]), 32'(od_c[2]), al_c[2], 32'(ag_c[2]), m[4]);
    endtask

    function automatic logic [7:0] pc(int k);
        return 8'((1 << k) - 1);
    endfunction

    initial begin
        int exp4 [4];
        int exps [3];
        int expa [5];
        exp4 = '{2, 3, 0, 0};
        exps = '{0, 1, 0};
        expa = '{1, 2, 3, 3, 3};
        reset = 1'b1; run = 1'b0; load_in = 1'b0; rule_we = 1'b0; load_out = 1'b0; shift = 1'b0;
        nbr = '0; rule_birth = '0; rule_survive = '0; din_x = '0; prev_x = '0;
        dc[0] = '0; dc[1] = '0; dc[2] = '0;

        // Reset state
        cyc();
        chk("reset.state", 32'(st_a), 0);
        chk("reset.out", 32'(od_b), 0);
        chk("reset.age", 32'(ag_a), 0);
        reset = 1'b0;

        // B3/S23 on an alive cell: popcount 2,3,4
        load_in = 1'b1; din_x = 3'd1; cyc(); load_in = 1'b0;
        chk("t1.load", 32'(st_a), 1);
        run = 1'b1;
        nbr = pc(2); cyc(); chk("t1.pop2", 32'(st_a), 1);
        nbr = pc(3); cyc(); chk("t1.pop3", 32'(st_a), 1);
        nbr = pc(4); cyc(); chk("t1.pop4", 32'(st_a), 0);

        // Birth from dead, then B36 rule
        nbr = pc(3); cyc(); chk("t2.birth3", 32'(st_a), 1);
        run = 1'b0; load_in = 1'b1; din_x = 3'd0; cyc(); load_in = 1'b0;
        run = 1'b1; nbr = pc(6); cyc(); chk("t2.pop6_b3", 32'(st_a), 0);
        run = 1'b0; rule_we = 1'b1; rule_birth = 9'h048; rule_survive = 9'h00C; cyc(); rule_we = 1'b0;
        run = 1'b1; cyc(); chk("t2.pop6_b36", 32'(st_a), 1);

        // Rule write in the same cycle as run uses the old masks
        run = 1'b0; load_in = 1'b1; din_x = 3'd0; cyc(); load_in = 1'b0;
        run = 1'b1; rule_we = 1'b1; rule_birth = 9'h004; nbr = pc(2); cyc(); rule_we = 1'b0;
        chk("t3.old_mask", 32'(st_a), 0);
        cyc(); chk("t3.new_mask", 32'(st_a), 1);

        // STATES=4 decay with all neighbours alive
        run = 1'b0; load_in = 1'b1; dc[0] = 2'd1; dc[1] = 2'd1; dc[2] = 2'd1; cyc(); load_in = 1'b0;
        rule_we = 1'b1; rule_birth = 9'h000; rule_survive = 9'h000; cyc(); rule_we = 1'b0;
        run = 1'b1; nbr = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            cyc(); chk("t4.decay", 32'(st_c[0]), 32'(exp4[i]));
        end
        run = 1'b0;

        // Shift chain: states 1,0,3 -> tail emits 3,0,1,0
        dc[0] = 2'd1; dc[1] = 2'd0; dc[2] = 2'd3; load_in = 1'b1; cyc(); load_in = 1'b0;
        load_out = 1'b1; cyc(); load_out = 1'b0;
        chk("t5.tail0", 32'(od_c[2]), 3);
        prev_x = '0; shift = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); chk("t5.tail", 32'(od_c[2]), 32'(exps[i]));
        end
        shift = 1'b0;

        // Age counting, saturation, load clear, reset with run active
        reset = 1'b1; cyc(); reset = 1'b0;
        rule_we = 1'b1; rule_birth = 9'h008; rule_survive = 9'h1FF; load_in = 1'b1; din_x = 3'd1;
        cyc(); rule_we = 1'b0; load_in = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nbr = 8'($urandom);
            cyc(); chk("t6.age", 32'(ag_a), AGE_EN ? 32'(expa[i]) : 0);
        end
        run = 1'b0; load_in = 1'b1; cyc(); load_in = 1'b0;
        chk("t6.age_load", 32'(ag_a), 0);
        run = 1'b1; cyc(); chk("t6.age_again", 32'(ag_a), AGE_EN ? 1 : 0);
        reset = 1'b1; cyc(); reset = 1'b0; run = 1'b0;
        chk("t6.rst_state", 32'(st_a), 0);
        chk("t6.rst_out", 32'(od_a), 0);
        chk("t6.rst_age", 32'(ag_a), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset        = ($urandom_range(0, 49) == 0);
            run          = ($urandom_range(0, 1) == 1);
            load_in      = ($urandom_range(0, 4) == 0);
            rule_we      = ($urandom_range(0, 9) == 0);
            load_out     = ($urandom_range(0, 6) == 0);
            shift        = ($urandom_range(0, 2) == 0);
            nbr          = 8'($urandom);
            rule_birth   = 9'($urandom);
            rule_survive = 9'($urandom);
            din_x        = 3'($urandom);
            prev_x       = 3'($urandom);
            dc[0] = 2'($urandom); dc[1] = 2'($urandom); dc[2] = 2'($urandom);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
